uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 159 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter (8N1) among NUM_REQ requesters.
// Define UART_TX_PARITY_EN to append an even-parity bit after the data bits.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ*8-1:0] data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 busy,
  output logic                 tx
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e        state_q, state_d;
  logic [TW-1:0] bitTimer_q, bitTimer_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    dataByte_q, dataByte_d;
  logic          tx_q, tx_d;

  logic          found;
  logic [PW-1:0] sel;
  logic [PW-1:0] selNext;
  logic [7:0]    selByte;
  logic          lastTick;

  // First requester with req high, scanning upward from the pointer with wrap.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[PW'(idx)]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
  end

  always_comb begin
    selByte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (sel == PW'(k)) selByte = data[8*k +: 8];
    end
    selNext = (int'(sel) == NUM_REQ - 1) ? '0 : sel + 1'b1;
  end

  assign lastTick = (bitTimer_q == LAST_TICK);

  always_comb begin
    state_d    = state_q;
    bitTimer_d = bitTimer_q;
    bitIdx_d   = bitIdx_q;
    ptr_d      = ptr_q;
    dataByte_d = dataByte_q;
    gnt        = '0;
    tx_d       = 1'b1;

    case (state_q)
      IDLE: begin
        bitTimer_d = '0;
        bitIdx_d   = '0;
        if (found) begin
          gnt[sel]   = 1'b1;
          dataByte_d = selByte;
          ptr_d      = selNext;
          state_d    = START;
        end
      end
      START: begin
        bitTimer_d = bitTimer_q + 1'b1;
        if (lastTick) begin
          bitTimer_d = '0;
          state_d    = DATA;
        end
      end
      DATA: begin
        bitTimer_d = bitTimer_q + 1'b1;
        if (lastTick) begin
          bitTimer_d = '0;
          bitIdx_d   = bitIdx_q + 3'd1;
          if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        bitTimer_d = bitTimer_q + 1'b1;
        if (lastTick) begin
          bitTimer_d = '0;
          state_d    = STOP;
        end
      end
`endif
      STOP: begin
        bitTimer_d = bitTimer_q + 1'b1;
        if (lastTick) begin
          bitTimer_d = '0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so the line level lines up with state_q.
    case (state_d)
      START:  tx_d = 1'b0;
      DATA:   tx_d = dataByte_d[bitIdx_d];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = ^dataByte_d;
`endif
      default: tx_d = 1'b1;
    endcase

    if (rst) gnt = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bitTimer_q <= '0;
      bitIdx_q   <= '0;
      ptr_q      <= '0;
      dataByte_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      bitTimer_q <= bitTimer_d;
      bitIdx_q   <= bitIdx_d;
      ptr_q      <= ptr_d;
      dataByte_q <= dataByte_d;
      tx_q       <= tx_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign tx   = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a queue-based line model.
// Honours UART_TX_PARITY_EN the same way as the design.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CPB     = 16;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME = FRAME_BITS * CPB;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ*8-1:0] data;
  logic [NUM_REQ-1:0]   gnt;
  logic                 busy;
  logic                 tx;

  int vectorCount = 0;
  int missCount   = 0;
  int cycleNum    = 0;
  bit checkEn     = 1'b0;

  // Expected line level per future cycle; empty means the transmitter is idle.
  bit modelLine[$];
  int modelPtr = 0;

  int obsGntIdx[$];
  int obsGntCyc[$];
  int busyRun     = 0;
  int lastBusyRun = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .data (data),
    .gnt  (gnt),
    .busy (busy),
    .tx   (tx)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s @cycle %0d: got %0h, expected %0h", tag, cycleNum, actual, expected);
    end
  endtask

  task automatic pushFrame(input logic [7:0] b);
    logic [FRAME_BITS-1:0] bits;
`ifdef UART_TX_PARITY_EN
    bits = {1'b1, ^b, b, 1'b0};
`else
    bits = {1'b1, b, 1'b0};
`endif
    for (int i = 0; i < FRAME_BITS; i++)
      repeat (CPB) modelLine.push_back(bits[i]);
  endtask

  task automatic runCycle(input logic rstV, input logic [NUM_REQ-1:0] reqV,
                          input logic [NUM_REQ*8-1:0] dataV);
    logic [NUM_REQ-1:0] expGnt;
    logic               expTx, expBusy;
    int                 winner;
    int                 obsIdx;
    @(negedge clk);
    rst  = rstV;
    req  = reqV;
    data = dataV;
    #1;
    cycleNum++;
    expTx   = (modelLine.size() > 0) ? modelLine[0] : 1'b1;
    expBusy = (modelLine.size() > 0);
    expGnt  = '0;
    winner  = -1;
    if (!rstV && modelLine.size() == 0 && reqV != '0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (winner < 0 && reqV[(modelPtr + k) % NUM_REQ]) winner = (modelPtr + k) % NUM_REQ;
      end
      expGnt[winner] = 1'b1;
    end
    if (checkEn) begin
      checkOutput("gnt", 32'(gnt), 32'(expGnt));
      checkOutput("tx", 32'(tx), 32'(expTx));
      checkOutput("busy", 32'(busy), 32'(expBusy));
    end
    if (gnt !== '0 && !$isunknown(gnt)) begin
      obsIdx = -1;
      for (int i = 0; i < NUM_REQ; i++) if (gnt[i]) obsIdx = i;
      obsGntIdx.push_back(obsIdx);
      obsGntCyc.push_back(cycleNum);
    end
    if (busy === 1'b1) busyRun++;
    else begin
      if (busyRun > 0) lastBusyRun = busyRun;
      busyRun = 0;
    end
    if (rstV) begin
      modelLine.delete();
      modelPtr = 0;
    end else if (modelLine.size() > 0) begin
      void'(modelLine.pop_front());
    end else if (winner >= 0) begin
      pushFrame(dataV[8*winner +: 8]);
      modelPtr = (winner + 1) % NUM_REQ;
    end
  endtask

  task automatic applyStimulus(input logic rstV, input logic [NUM_REQ-1:0] reqV,
                               input logic [NUM_REQ*8-1:0] dataV, input int n);
    for (int i = 0; i < n; i++) runCycle(rstV, reqV, dataV);
  endtask

  int                   base;
  int                   rstCycle;
  logic [NUM_REQ-1:0]   rndReq;
  logic [NUM_REQ*8-1:0] rndData;
  int                   rndLen;

  initial begin
    rst  = 1'b1;
    req  = '0;
    data = '0;
    applyStimulus(1'b1, '0, '0, 1);
    checkEn = 1'b1;
    applyStimulus(1'b1, '0, '0, 2);
    checkOutput("reset_tx", 32'(tx), 32'd1);
    checkOutput("reset_busy", 32'(busy), 32'd0);

    // Single A5 frame from requester 0.
    base = obsGntIdx.size();
    applyStimulus(1'b0, 4'b0001, 32'h0000_00A5, 1);
    applyStimulus(1'b0, '0, 32'h0000_00A5, FRAME + 2);
    checkOutput("a5_gnt_count", 32'(obsGntIdx.size() - base), 32'd1);
    checkOutput("a5_frame_len", 32'(lastBusyRun), 32'(FRAME));

    // All requesters held: strict rotation with frame+1 spacing.
    applyStimulus(1'b1, '0, '0, 1);
    base = obsGntIdx.size();
    applyStimulus(1'b0, 4'b1111, 32'h1122_3344, 5 * (FRAME + 1));
    checkOutput("rr_count", 32'(obsGntIdx.size() - base), 32'd5);
    if (obsGntIdx.size() - base >= 5) begin
      checkOutput("rr_order0", 32'(obsGntIdx[base]),     32'd0);
      checkOutput("rr_order1", 32'(obsGntIdx[base + 1]), 32'd1);
      checkOutput("rr_order2", 32'(obsGntIdx[base + 2]), 32'd2);
      checkOutput("rr_order3", 32'(obsGntIdx[base + 3]), 32'd3);
      checkOutput("rr_order4", 32'(obsGntIdx[base + 4]), 32'd0);
      for (int k = 1; k < 5; k++)
        checkOutput("rr_spacing", 32'(obsGntCyc[base + k] - obsGntCyc[base + k - 1]), 32'(FRAME + 1));
    end
    applyStimulus(1'b0, '0, '0, FRAME + 1);

    // Pointer after a grant to 1 favours 0 over 1, then 1 comes next.
    applyStimulus(1'b1, '0, '0, 1);
    applyStimulus(1'b0, 4'b0010, 32'h0000_3C00, 1);
    applyStimulus(1'b0, '0, '0, FRAME + 1);
    base = obsGntIdx.size();
    applyStimulus(1'b0, 4'b0011, 32'h0000_3C5A, 1);
    applyStimulus(1'b0, '0, '0, FRAME + 1);
    applyStimulus(1'b0, 4'b0011, 32'h0000_3C5A, 1);
    applyStimulus(1'b0, '0, '0, FRAME + 1);
    checkOutput("ptr_count", 32'(obsGntIdx.size() - base), 32'd2);
    if (obsGntIdx.size() - base >= 2) begin
      checkOutput("ptr_wrap_to0", 32'(obsGntIdx[base]), 32'd0);
      checkOutput("ptr_then1", 32'(obsGntIdx[base + 1]), 32'd1);
    end

    // Requester 3 asks mid-frame and withdraws before the frame ends.
    base = obsGntIdx.size();
    applyStimulus(1'b0, 4'b0001, 32'h0000_0081, 1);
    applyStimulus(1'b0, 4'b1000, 32'hEE00_0081, 60);
    applyStimulus(1'b0, '0, '0, FRAME + 5);
    checkOutput("drop_gnt_count", 32'(obsGntIdx.size() - base), 32'd1);

    // Reset during data bit 4, requester 2 already waiting.
    applyStimulus(1'b0, 4'b0001, 32'h0000_00FF, 1);
    applyStimulus(1'b0, '0, 32'h0000_00FF, 5 * CPB + 4);
    applyStimulus(1'b1, 4'b0100, 32'h0096_0000, 1);
    rstCycle = cycleNum;
    base = obsGntIdx.size();
    applyStimulus(1'b0, 4'b0100, 32'h0096_0000, 1);
    checkOutput("rst_mid_tx", 32'(tx), 32'd1);
    checkOutput("rst_mid_gnt_count", 32'(obsGntIdx.size() - base), 32'd1);
    if (obsGntIdx.size() - base >= 1) begin
      checkOutput("rst_mid_gnt_idx", 32'(obsGntIdx[base]), 32'd2);
      checkOutput("rst_mid_gnt_cyc", 32'(obsGntCyc[base] - rstCycle), 32'd1);
    end
    applyStimulus(1'b0, '0, '0, FRAME + 2);

    // Byte 07: parity bit is 1 when enabled; frame length follows the build.
    applyStimulus(1'b0, 4'b0001, 32'h0000_0007, 1);
    applyStimulus(1'b0, '0, '0, FRAME + 3);
    checkOutput("b07_frame_len", 32'(lastBusyRun), 32'(FRAME));

    // Randomized traffic including occasional resets.
    for (int it = 0; it < 40; it++) begin
      rndReq  = NUM_REQ'($urandom);
      rndData = $urandom;
      rndLen  = $urandom_range(1, FRAME + 30);
      if ($urandom_range(0, 15) == 0) applyStimulus(1'b1, rndReq, rndData, $urandom_range(1, 3));
      else applyStimulus(1'b0, rndReq, rndData, rndLen);
    end
    applyStimulus(1'b0, '0, '0, FRAME + 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
